sub_serial: RTL and testbench

//   Bit-serial subtractor; companion to the serial adder in the same datapath.

---
 rtl/sub_serial_pkg.sv | 20 ++
 rtl/sub_serial_if.sv | 24 ++
 rtl/sub_serial_bit.sv | 15 +
 rtl/sub_serial.sv | 150 +++++++++++++++
 tb/tb_sub_serial.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/sub_serial_pkg.sv
// Shared definitions for the serial add/subtract datapath: the common state
// encoding and the default operand width.
package serial_arith_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // ADD belongs to the serial adder; the subtractor treats it as illegal.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2,
    ADD  = 2'd3
  } state_t;

  // Borrow out of one full-subtractor cell computing x - y - bin.
  function automatic logic sub_borrow(input logic x, input logic y, input logic bin);
    return (~x & y) | (~(x ^ y) & bin);
  endfunction

endpackage

// File: rtl/sub_serial_if.sv
// Request/result bundle between a requester and the bit-serial subtractor.
interface sub_serial_if
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             en;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] out;
  logic             underflow;
  logic             busy;
  logic             done;

  modport master (
    output en, a, b,
    input  out, underflow, busy, done
  );

  modport slave (
    input  en, a, b,
    output out, underflow, busy, done
  );
endinterface

// File: rtl/sub_serial_bit.sv
// Single combinational full-subtractor cell: x - y - bin -> (d, bout).
module full_sub_bit
  import serial_arith_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = sub_borrow(x, y, bin);

endmodule

// File: rtl/sub_serial.sv
// Bit-serial subtractor: latches a and b, produces a-b LSB-first over WIDTH
// clocks through one full-subtractor cell, and reports the final borrow.
module sub_serial
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
)(
  input  logic       clk,
  input  logic       rst,
  sub_serial_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] out_r;
  logic             borrow_r;
  logic [CNT_W-1:0] count_r;
  logic             busy_r;
  logic             done_r;

  logic             start_s;
  logic             step_s;
  logic             last_s;
  logic             d_s;
  logic             bout_s;

  assign last_s = (count_r == CNT_W'(WIDTH - 1));

  full_sub_bit u_cell (
    .x    (a_r[0]),
    .y    (b_r[0]),
    .bin  (borrow_r),
    .d    (d_s),
    .bout (bout_s)
  );

  // Next-state decode plus the load/shift strobes for the datapath.
  always_comb begin
    state_s = state_r;
    start_s = 1'b0;
    step_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.en) begin
          state_s = SUB;
          start_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      SUB: begin
        step_s = 1'b1;
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = SUB;
        end
      end
      DONE: begin
        if (bus.en) begin
          state_s = DONE;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register with busy/done registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == SUB);
      done_r  <= (state_s == DONE);
    end
  end

  // Operand shift registers: load on start, shift right once per bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
    end else if (start_s) begin
      a_r <= bus.a;
      b_r <= bus.b;
    end else if (step_s) begin
      a_r <= {1'b0, a_r[WIDTH-1:1]};
      b_r <= {1'b0, b_r[WIDTH-1:1]};
    end else begin
      a_r <= a_r;
      b_r <= b_r;
    end
  end

  // Result register fills from the MSB end so bit 0 lands last in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r <= '0;
    end else if (start_s) begin
      out_r <= '0;
    end else if (step_s) begin
      out_r <= {d_s, out_r[WIDTH-1:1]};
    end else begin
      out_r <= out_r;
    end
  end

  // Borrow flop; its final value is the underflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      borrow_r <= 1'b0;
    end else if (start_s) begin
      borrow_r <= 1'b0;
    end else if (step_s) begin
      borrow_r <= bout_s;
    end else begin
      borrow_r <= borrow_r;
    end
  end

  // Bit counter; saturates at the last bit rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (start_s) begin
      count_r <= '0;
    end else if (step_s && !last_s) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign bus.out       = out_r;
  assign bus.underflow = borrow_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

endmodule

// File: tb/tb_sub_serial.sv
// Randomised self-checking bench for sub_serial at WIDTH=8 and WIDTH=16,
// compared against a plain (WIDTH+1)-bit subtraction model.
module tb_sub_serial;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  sub_serial_if #(.WIDTH(8))  bus8 ();
  sub_serial_if #(.WIDTH(16)) bus16 ();

  sub_serial #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
  sub_serial #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  // mode 0: en pulsed one cycle; 1: en/a/b scrambled during SUB; 2: en held through DONE
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input int mode, input string tag);
    logic [8:0] full;
    full = {1'b0, a} - {1'b0, b};
    @(negedge clk);
    bus8.en = 1'b1; bus8.a = a; bus8.b = b;
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vectors++;
      if (bus8.busy !== 1'b1 || bus8.done !== 1'b0) begin
        errors++;
        $display("FAIL %s busy cycle %0d: busy=%b done=%b, required busy=1 done=0", tag, i, bus8.busy, bus8.done);
      end
      if (mode == 1) begin
        bus8.en = 1'($urandom_range(0, 1)); bus8.a = 8'($urandom); bus8.b = 8'($urandom);
      end else if (mode == 2) begin
        bus8.en = 1'b1;
      end else begin
        bus8.en = 1'b0;
      end
      @(posedge clk);
    end
    @(negedge clk);
    vectors++;
    if (bus8.done !== 1'b1 || bus8.busy !== 1'b0 || bus8.out !== full[7:0] || bus8.underflow !== full[8]) begin
      errors++;
      $display("FAIL %s result: done=%b busy=%b out=%h uf=%b, required done=1 busy=0 out=%h uf=%b",
               tag, bus8.done, bus8.busy, bus8.out, bus8.underflow, full[7:0], full[8]);
    end
    if (mode == 2) begin
      for (int i = 0; i < 3; i++) begin
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus8.done !== 1'b1 || bus8.busy !== 1'b0 || bus8.out !== full[7:0]) begin
          errors++;
          $display("FAIL %s hold: done=%b busy=%b out=%h, required done=1 busy=0 out=%h",
                   tag, bus8.done, bus8.busy, bus8.out, full[7:0]);
        end
      end
    end
    bus8.en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (bus8.done !== 1'b0 || bus8.busy !== 1'b0 || bus8.out !== full[7:0] || bus8.underflow !== full[8]) begin
      errors++;
      $display("FAIL %s release: done=%b busy=%b out=%h uf=%b, required done=0 busy=0 out=%h uf=%b",
               tag, bus8.done, bus8.busy, bus8.out, bus8.underflow, full[7:0], full[8]);
    end
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] full;
    int          busy_cnt;
    full = {1'b0, a} - {1'b0, b};
    busy_cnt = 0;
    @(negedge clk);
    bus16.en = 1'b1; bus16.a = a; bus16.b = b;
    @(posedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus16.en = 1'b0;
      if (bus16.busy === 1'b1) busy_cnt++;
      @(posedge clk);
    end
    @(negedge clk);
    vectors++;
    if (busy_cnt != 16 || bus16.done !== 1'b1 || bus16.out !== full[15:0] || bus16.underflow !== full[16]) begin
      errors++;
      $display("FAIL rand16 a=%h b=%h: busy_cycles=%0d done=%b out=%h uf=%b, required 16 1 %h %b",
               a, b, busy_cnt, bus16.done, bus16.out, bus16.underflow, full[15:0], full[16]);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus8.en = 1'b0;  bus8.a = '0;  bus8.b = '0;
    bus16.en = 1'b0; bus16.a = '0; bus16.b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (bus8.out !== 8'h00 || bus8.underflow !== 1'b0 || bus8.busy !== 1'b0 || bus8.done !== 1'b0 ||
        bus16.out !== 16'h0000 || bus16.busy !== 1'b0 || bus16.done !== 1'b0) begin
      errors++;
      $display("FAIL reset: out8=%h uf=%b busy=%b done=%b out16=%h, required all zero",
               bus8.out, bus8.underflow, bus8.busy, bus8.done, bus16.out);
    end
  endtask

  task automatic test_basic();
    run8(8'd100, 8'd58, 0, "basic");
  endtask

  task automatic test_boundaries();
    run8(8'd5, 8'd9, 0, "neg");
    run8(8'd0, 8'd1, 0, "ripple");
    run8(8'hAA, 8'hAA, 0, "equal");
    run8(8'hFF, 8'h00, 0, "max_minus_zero");
    run8(8'h00, 8'hFF, 0, "zero_minus_max");
  endtask

  task automatic test_ignore_inputs();
    for (int i = 0; i < 4; i++) begin
      run8(8'($urandom), 8'($urandom), 1, "scramble");
    end
  endtask

  task automatic test_en_hold();
    run8(8'd33, 8'd77, 2, "en_hold");
    run8(8'd200, 8'd1, 0, "restart");
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    bus8.en = 1'b1; bus8.a = 8'd90; bus8.b = 8'd17;
    @(posedge clk);
    @(negedge clk);
    bus8.en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.out !== 8'h00 || bus8.underflow !== 1'b0) begin
      errors++;
      $display("FAIL abort: busy=%b done=%b out=%h uf=%b, required 0 0 00 0",
               bus8.busy, bus8.done, bus8.out, bus8.underflow);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin
        errors++;
        $display("FAIL abort_idle cycle %0d: busy=%b done=%b, required 0 0", i, bus8.busy, bus8.done);
      end
    end
    run8(8'd7, 8'd3, 0, "after_abort");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      run8(8'($urandom), 8'($urandom), 0, "rand8");
    end
    for (int i = 0; i < 20; i++) begin
      run16(16'($urandom), 16'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_ignore_inputs();
    test_en_hold();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
